alu_serial_sequencer: RTL and testbench

- Bit-serial ALU engine that drives one internal 1-bit ALU slice across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Feeds each slice's CarryOut back into the next bit's CarryIn and collects Result bits into a WIDTH-bit register.
- This is the synthesizable initiator side of the 1-bit ALU interface: it generates a, b, CarryIn and ALUOp, and consumes Result and CarryOut.
- Sits between a multi-cycle datapath controller and the register file.

---
 rtl/alu_serial_sequencer.sv | 119 +++++++++++
 tb/tb_alu_serial_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU engine: walks one 1-bit ALU slice across a WIDTH-bit operand
// pair, LSB first, chaining the slice carry and collecting result bits.
module alu_serial_sequencer #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [3:0]       op_r;
   logic             carry;
   logic [WIDTH-1:0] shift_r;

   logic             bit_a;
   logic             bit_b;
   logic             b_eff;
   logic             res_bit;
   logic             carry_next;
   logic [WIDTH-1:0] shift_next;

   // The 1-bit ALU slice; only ADD/SUB produce a carry.
   always_comb begin
      bit_a      = a_r[idx];
      bit_b      = b_r[idx];
      b_eff      = (op_r == OP_SUB) ? ~bit_b : bit_b;
      res_bit    = 1'b0;
      carry_next = 1'b0;
      case (op_r)
         OP_AND: res_bit = bit_a & bit_b;
         OP_OR:  res_bit = bit_a | bit_b;
         OP_NOR: res_bit = ~(bit_a | bit_b);
         OP_ADD, OP_SUB: begin
            res_bit    = bit_a ^ b_eff ^ carry;
            carry_next = (bit_a & b_eff) | (bit_a & carry) | (b_eff & carry);
         end
         default: ;
      endcase
      shift_next = {res_bit, shift_r[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         op_r      <= '0;
         carry     <= 1'b0;
         shift_r   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b1;
      end else begin
         case (state)
            // DONE accepts a new start exactly like IDLE (back-to-back ops).
            S_IDLE, S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
               if (start) begin
                  a_r     <= a_in;
                  b_r     <= b_in;
                  op_r    <= alu_op;
                  idx     <= '0;
                  carry   <= (alu_op == OP_SUB);
                  shift_r <= '0;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               shift_r <= shift_next;
               carry   <= carry_next;
               idx     <= idx + 1'b1;
               if (idx == IDX_W'(WIDTH - 1)) begin
                  idx       <= '0;
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result    <= shift_next;
                  carry_out <= carry_next;
                  zero      <= ~|shift_next;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: directed cases plus random
// operations against an arithmetic reference model, at WIDTH=8 and WIDTH=64.
module tb_alu_serial_sequencer;

   logic        clk;
   logic        reset;

   logic        start8;
   logic [7:0]  a_in8, b_in8;
   logic [3:0]  alu_op8;
   logic        busy8, done8, carry_out8, zero8;
   logic [7:0]  result8;

   logic        start64;
   logic [63:0] a_in64, b_in64;
   logic [3:0]  alu_op64;
   logic        busy64, done64, carry_out64, zero64;
   logic [63:0] result64;

   int          checks = 0;
   int          fails  = 0;
   logic [64:0] exp8;
   logic [7:0]  prev8;

   alu_serial_sequencer #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .a_in(a_in8), .b_in(b_in8),
      .alu_op(alu_op8), .busy(busy8), .done(done8), .result(result8),
      .carry_out(carry_out8), .zero(zero8)
   );

   alu_serial_sequencer #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .start(start64), .a_in(a_in64), .b_in(b_in64),
      .alu_op(alu_op64), .busy(busy64), .done(done64), .result(result64),
      .carry_out(carry_out64), .zero(zero64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {carry_out, result} computed with ordinary arithmetic.
   function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
      logic [64:0] mask, s;
      logic [63:0] am, bm, r;
      logic        c;
      mask = (65'd1 << w) - 65'd1;
      am = a & mask[63:0];
      bm = b & mask[63:0];
      c  = 1'b0;
      case (op)
         4'b0000: r = am & bm;
         4'b0001: r = am | bm;
         4'b0010: begin s = {1'b0, am} + {1'b0, bm}; r = s[63:0]; c = s[w]; end
         4'b0110: begin r = am - bm; c = (am >= bm); end
         4'b1100: r = ~(am | bm);
         default: r = '0;
      endcase
      r = r & mask[63:0];
      return {c, r};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      a_in8 = a; b_in8 = b; alu_op8 = op; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      exp8 = model(op, {56'd0, a}, {56'd0, b}, 8);
      check("busy_after_start", {63'd0, busy8}, 64'd1);
      check("done_low_after_start", {63'd0, done8}, 64'd0);
      check("result_held_at_start", {56'd0, result8}, {56'd0, prev8});
      // Later input changes must not reach the running operation.
      a_in8 = 8'($urandom); b_in8 = 8'($urandom); alu_op8 = 4'($urandom);
   endtask

   task automatic wait_done8(input string tag, input int already);
      int cnt;
      cnt = already;
      while (done8 !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      check({tag, "_latency"}, 64'(cnt), 64'd9);
      check({tag, "_result"}, {56'd0, result8}, {56'd0, exp8[7:0]});
      check({tag, "_carry"}, {63'd0, carry_out8}, {63'd0, exp8[64]});
      check({tag, "_zero"}, {63'd0, zero8}, {63'd0, (exp8[7:0] == 8'd0)});
      check({tag, "_busy_low"}, {63'd0, busy8}, 64'd0);
      prev8 = exp8[7:0];
   endtask

   task automatic done_ends8(input string tag);
      @(posedge clk); #1;
      check({tag, "_done_pulse_end"}, {63'd0, done8}, 64'd0);
      check({tag, "_result_hold"}, {56'd0, result8}, {56'd0, prev8});
   endtask

   task automatic run64(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b);
      int          cnt;
      logic [64:0] e;
      e = model(op, a, b, 64);
      @(negedge clk);
      a_in64 = a; b_in64 = b; alu_op64 = op; start64 = 1'b1;
      @(posedge clk); #1;
      start64 = 1'b0;
      a_in64 = {$urandom, $urandom}; b_in64 = {$urandom, $urandom};
      cnt = 1;
      while (done64 !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      check({tag, "_latency"}, 64'(cnt), 64'd65);
      check({tag, "_result"}, result64, e[63:0]);
      check({tag, "_carry"}, {63'd0, carry_out64}, {63'd0, e[64]});
      check({tag, "_zero"}, {63'd0, zero64}, {63'd0, (e[63:0] == 64'd0)});
   endtask

   initial begin
      reset = 1'b1;
      start8 = 1'b0; a_in8 = '0; b_in8 = '0; alu_op8 = '0;
      start64 = 1'b0; a_in64 = '0; b_in64 = '0; alu_op64 = '0;
      prev8 = '0;
      exp8 = '0;
      @(posedge clk); #1;
      check("rst_busy", {63'd0, busy8}, 64'd0);
      check("rst_done", {63'd0, done8}, 64'd0);
      check("rst_result", {56'd0, result8}, 64'd0);
      check("rst_carry", {63'd0, carry_out8}, 64'd0);
      check("rst_zero", {63'd0, zero8}, 64'd1);
      check("rst_zero64", {63'd0, zero64}, 64'd1);
      @(negedge clk);
      reset = 1'b0;

      start_op8(4'b0010, 8'hFF, 8'h01);
      wait_done8("add_ff_01", 1);
      check("add_ff_01_lit", {55'd0, carry_out8, result8}, {55'd0, 1'b1, 8'h00});
      done_ends8("add_ff_01");

      start_op8(4'b0110, 8'h05, 8'h07);
      wait_done8("sub_05_07", 1);
      check("sub_05_07_lit", {55'd0, carry_out8, result8}, {55'd0, 1'b0, 8'hFE});
      start_op8(4'b0110, 8'h07, 8'h07);
      wait_done8("sub_07_07", 1);
      check("sub_07_07_lit", {55'd0, carry_out8, result8}, {55'd0, 1'b1, 8'h00});
      done_ends8("sub_07_07");

      start_op8(4'b0000, 8'hF0, 8'h3C);
      wait_done8("and", 1);
      check("and_lit", {56'd0, result8}, {56'd0, 8'h30});
      start_op8(4'b0001, 8'hF0, 8'h3C);
      wait_done8("or", 1);
      check("or_lit", {56'd0, result8}, {56'd0, 8'hFC});
      start_op8(4'b1100, 8'hF0, 8'h3C);
      wait_done8("nor", 1);
      check("nor_lit", {56'd0, result8}, {56'd0, 8'h03});
      start_op8(4'b0011, 8'hF0, 8'h3C);
      wait_done8("op0011", 1);
      check("op0011_lit", {55'd0, carry_out8, result8}, 64'd0);
      done_ends8("op0011");

      // A start pulse while busy is ignored; then a back-to-back start on done.
      start_op8(4'b0010, 8'h10, 8'h20);
      @(posedge clk); #1;
      @(negedge clk);
      a_in8 = 8'h55; b_in8 = 8'h66; alu_op8 = 4'b0110; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("ignored_start_busy", {63'd0, busy8}, 64'd1);
      wait_done8("ignored_start", 3);
      check("ignored_start_lit", {56'd0, result8}, {56'd0, 8'h30});
      start_op8(4'b0110, 8'h40, 8'h01);
      wait_done8("back_to_back", 1);
      done_ends8("back_to_back");

      // Reset in the middle of an ADD aborts it without a done pulse.
      start_op8(4'b0010, 8'h12, 8'h34);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_busy", {63'd0, busy8}, 64'd0);
      check("midrst_result", {56'd0, result8}, 64'd0);
      check("midrst_zero", {63'd0, zero8}, 64'd1);
      check("midrst_carry", {63'd0, carry_out8}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      prev8 = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("midrst_no_done", {63'd0, done8}, 64'd0);
      end
      start_op8(4'b0010, 8'h21, 8'h0F);
      wait_done8("after_rst", 1);
      check("after_rst_lit", {56'd0, result8}, {56'd0, 8'h30});
      done_ends8("after_rst");

      for (int i = 0; i < 24; i++) begin
         logic [3:0] op;
         case ($urandom_range(0, 5))
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0010;
            3: op = 4'b0110;
            4: op = 4'b1100;
            default: op = 4'($urandom);
         endcase
         start_op8(op, 8'($urandom), 8'($urandom));
         wait_done8("rand8", 1);
      end
      done_ends8("rand8");

      run64("add64_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      check("add64_wrap_lit", {result64[62:0], carry_out64}, 64'd1);
      run64("sub64_rand", 4'b0110, {$urandom, $urandom}, {$urandom, $urandom});
      run64("add64_rand", 4'b0010, {$urandom, $urandom}, {$urandom, $urandom});

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
